size_exploration_driver: RTL
============================

# size_exploration_driver

Host-side counterpart of the size-exploration tile wrapper. It accepts three 32-bit operands on a valid/ready command port, streams them MSB-first onto the wrapper's three serial input lanes (ui_in[0..2]), steers the byte-select line (ui_in[7]), and reassembles the 32-bit result from the two 8-bit result buses. It sits in the FPGA/bench harness that drives the tile, or in an on-chip self-test wrapper.

## Interface
Parameters:
- SHIFT_LEN, 32, length of each of the tile's free-running input shift registers.
- CAPTURE_OFFSET, 0, extra cycles between operand alignment and result sampling; 0 for combinational components (MULT, ADDER), the pipeline depth for FMA. Legal range 0..SHIFT_LEN-2.

Ports:
- clk  in  1  single clock, shared with the tile.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  operand set valid.
- cmd_ready  out  1  driver idle and able to accept.
- cmd_a, cmd_b, cmd_c  in  32 each  operands for lanes 0, 1, 2.
- ser_a, ser_b, ser_c  out  1 each  registered serial bits to ui_in[0], ui_in[1], ui_in[2].
- dut_sel  out  1  to ui_in[7]; 1 selects the low byte of each half.
- res_lo  in  8  from uo_out: result[7:0] when sel=1, result[15:8] when sel=0.
- res_hi  in  8  from uio_out: result[23:16] when sel=1, result[31:24] when sel=0.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  32  reassembled result.

## Operation
- States: IDLE, STREAM, RESP. A 7-bit cycle counter is active in STREAM.
- IDLE: cmd_ready=1. On cmd_valid: latch operands, counter=0, go to STREAM.
- STREAM: each cycle, every lane drives the current MSB of its operand register and rotates that register left by 1. The word recirculates, so the tile register holds the exact operand every SHIFT_LEN cycles.
- dut_sel=1 from acceptance through the low-half capture edge, then 0.
- Low capture: {res_hi,res_lo} into rsp_data[23:16],[7:0].
- High capture: into rsp_data[31:24],[15:8]. Then go to RESP.
- RESP: rsp_valid=1, with rsp_data and ser/sel outputs frozen until rsp_ready. rsp_valid&rsp_ready returns to IDLE, and cmd_ready rises in the next cycle; there is no back-to-back overlap.
- IDLE and RESP drive ser_* = 0. A new command is never accepted while STREAM or RESP is active.
- reset: state IDLE, counter 0, operands 0. Outputs after reset: ser_a/b/c=0, dut_sel=0, cmd_ready=1, rsp_valid=0, rsp_data=0. Reset during STREAM or RESP aborts the transfer with no response.

## Timing
- E0 = acceptance edge; Ek = k-th edge after it.
- ser_* carries operand bit 31-k during the cycle after E(k). The tile samples it at E(k+1).
- The tile register equals the operand after E32 and again after E64.
- Low capture at E(33+CAPTURE_OFFSET); dut_sel falls at that edge.
- High capture at E(65+CAPTURE_OFFSET).
- rsp_valid rises at E(65+CAPTURE_OFFSET): latency 65+CAPTURE_OFFSET cycles.
- Rotation continues through both capture edges. The final rotated state is irrelevant.
- rsp_ready held high gives 1 cycle in RESP; cmd_ready is high in the following cycle.

## Structure
- Package size_exploration_pkg holds the state enum, SHIFT_LEN default, capture-edge constants (ALIGN_LO=33, ALIGN_HI=65) and the byte-lane mapping constants.
- Sub-module: sx_rotator, a parallel-load, rotate-left 32-bit lane with registered MSB output. Instantiate it 3 times.
- The top holds the FSM, counter, sel and capture logic.

## Test plan
All scenarios run against a behavioural model of the tile wrapper (3 shift registers, ui_in[7] byte mux).
- MULT width 8, a=0x0000000F, b=0x0000000D -> rsp_data=0x000000C3 exactly 65 cycles after acceptance; dut_sel falls at E33.
- ADDER width 8, a=0x000000FF, b=0x00000001 -> rsp_data=0x00000100. Driving pattern a=0xA5A5A5A5 -> ser_a over E0..E31 equals 1,0,1,0,0,1,0,1,... (MSB first).
- Full-width check with a 32-bit pass-through model, result=a: a=0xDEADBEEF -> 0xDEADBEEF, verifying all four byte lanes and their sel mapping.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, cmd_valid ignored; release -> one handshake, cmd_ready=1 the next cycle.
- Reset asserted at E40 -> next cycle all outputs at reset values and no rsp_valid. A new command a=3, b=5 (MULT) then yields 0x0000000F.
- CAPTURE_OFFSET=2 with a 2-stage registered multiplier model, a=7, b=9 -> 0x0000003F at E67.

Source files
------------

// File: rtl/size_exploration_pkg.sv
// Shared types and constants for the size-exploration tile driver.
package size_exploration_pkg;

  // Operand / result width and default tile shift-register length.
  localparam int OPER_W        = 32;
  localparam int SHIFT_LEN_DEF = 32;
  localparam int BYTE_W        = 8;

  // Streaming cycle counter width (covers 2*SHIFT_LEN + max offset).
  localparam int CNT_W = 7;

  // Edges (after acceptance) at which the tile output is aligned and sampled.
  localparam int ALIGN_LO = 33;
  localparam int ALIGN_HI = 65;

  // Bit position in rsp_data of each result byte, per bus and sel level.
  localparam int LANE_LO_SEL1 = 0;   // res_lo while sel=1 -> result[7:0]
  localparam int LANE_HI_SEL1 = 16;  // res_hi while sel=1 -> result[23:16]
  localparam int LANE_LO_SEL0 = 8;   // res_lo while sel=0 -> result[15:8]
  localparam int LANE_HI_SEL0 = 24;  // res_hi while sel=0 -> result[31:24]

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Counter value seen just before the capture edge E(align_edge + offset);
  // the counter is 0 after E0 and increments on every streaming edge.
  function automatic logic [CNT_W-1:0] capture_cnt(input int align_edge, input int offset);
    return CNT_W'(align_edge - 1 + offset);
  endfunction

endpackage

// File: rtl/size_exploration_driver_if.sv
// Command, response and tile-side signal bundle of the driver.
interface size_exploration_driver_if;
  import size_exploration_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OPER_W-1:0] cmd_a;
  logic [OPER_W-1:0] cmd_b;
  logic [OPER_W-1:0] cmd_c;
  logic              ser_a;
  logic              ser_b;
  logic              ser_c;
  logic              dut_sel;
  logic [BYTE_W-1:0] res_lo;
  logic [BYTE_W-1:0] res_hi;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [OPER_W-1:0] rsp_data;

  // Driver side.
  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_c, res_lo, res_hi, rsp_ready,
    output cmd_ready, ser_a, ser_b, ser_c, dut_sel, rsp_valid, rsp_data
  );

  // Host plus tile side.
  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_c, res_lo, res_hi, rsp_ready,
    input  cmd_ready, ser_a, ser_b, ser_c, dut_sel, rsp_valid, rsp_data
  );

endinterface

// File: rtl/sx_rotator.sv
// One serial lane: parallel-load word register that rotates left and
// presents its MSB on a registered serial output.
module sx_rotator
  import size_exploration_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,   // accept a new operand
  input  logic              shift_i,  // streaming cycle
  input  logic              clear_i,  // leave streaming: force serial output low
  input  logic [OPER_W-1:0] data_i,
  output logic              ser_o
);

  logic [OPER_W-1:0] word_q, word_d;
  logic              ser_q, ser_d;

  // Next word / serial bit: load presents the MSB immediately and stores the
  // already-rotated word so the following edge emits the next bit.
  always_comb begin
    word_d = word_q;
    ser_d  = ser_q;
    if (load_i) begin
      word_d = {data_i[OPER_W-2:0], data_i[OPER_W-1]};
      ser_d  = data_i[OPER_W-1];
    end else if (clear_i) begin
      word_d = {word_q[OPER_W-2:0], word_q[OPER_W-1]};
      ser_d  = 1'b0;
    end else if (shift_i) begin
      word_d = {word_q[OPER_W-2:0], word_q[OPER_W-1]};
      ser_d  = word_q[OPER_W-1];
    end else begin
      word_d = word_q;
      ser_d  = ser_q;
    end
  end

  // Lane state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      ser_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      ser_q  <= ser_d;
    end
  end

  assign ser_o = ser_q;

endmodule

// File: rtl/size_exploration_driver.sv
// Host-side driver for the size-exploration tile: streams three operands
// MSB-first into the tile's free-running shift registers and reassembles the
// 32-bit result from the two byte buses in two aligned captures.
module size_exploration_driver
  import size_exploration_pkg::*;
#(
  parameter int SHIFT_LEN      = SHIFT_LEN_DEF,
  parameter int CAPTURE_OFFSET = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  size_exploration_driver_if.master   bus_if
);

  // Alignment edges move with the tile register length.
  localparam int EDGE_SHIFT = SHIFT_LEN - SHIFT_LEN_DEF;
  localparam logic [CNT_W-1:0] CNT_LO = capture_cnt(ALIGN_LO + EDGE_SHIFT, CAPTURE_OFFSET);
  localparam logic [CNT_W-1:0] CNT_HI = capture_cnt(ALIGN_HI + 2 * EDGE_SHIFT, CAPTURE_OFFSET);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dut_sel_q, dut_sel_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [OPER_W-1:0]   rsp_data_q, rsp_data_d;
  logic                accept_s;
  logic                shift_s;
  logic                cap_hi_s;

  // FSM next state, counter, byte-select and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dut_sel_d  = dut_sel_q;
    rsp_data_d = rsp_data_q;
    accept_s   = 1'b0;
    shift_s    = 1'b0;
    cap_hi_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.cmd_valid) begin
          accept_s  = 1'b1;
          cnt_d     = '0;
          dut_sel_d = 1'b1;
          state_d   = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        shift_s = 1'b1;
        cnt_d   = cnt_q + 7'd1;
        if (cnt_q == CNT_LO) begin
          // Low-half sample; the tile sees sel drop on this same edge.
          rsp_data_d[LANE_LO_SEL1 +: BYTE_W] = bus_if.res_lo;
          rsp_data_d[LANE_HI_SEL1 +: BYTE_W] = bus_if.res_hi;
          dut_sel_d = 1'b0;
        end else begin
          dut_sel_d = dut_sel_q;
        end
        if (cnt_q == CNT_HI) begin
          rsp_data_d[LANE_LO_SEL0 +: BYTE_W] = bus_if.res_lo;
          rsp_data_d[LANE_HI_SEL0 +: BYTE_W] = bus_if.res_hi;
          cap_hi_s = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RESP;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_RESP: begin
        if (bus_if.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        dut_sel_d = 1'b0;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dut_sel_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dut_sel_q   <= dut_sel_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  sx_rotator u_rot_a (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept_s),
    .shift_i (shift_s),
    .clear_i (cap_hi_s),
    .data_i  (bus_if.cmd_a),
    .ser_o   (bus_if.ser_a)
  );

  sx_rotator u_rot_b (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept_s),
    .shift_i (shift_s),
    .clear_i (cap_hi_s),
    .data_i  (bus_if.cmd_b),
    .ser_o   (bus_if.ser_b)
  );

  sx_rotator u_rot_c (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept_s),
    .shift_i (shift_s),
    .clear_i (cap_hi_s),
    .data_i  (bus_if.cmd_c),
    .ser_o   (bus_if.ser_c)
  );

  assign bus_if.cmd_ready = cmd_ready_q;
  assign bus_if.dut_sel   = dut_sel_q;
  assign bus_if.rsp_valid = rsp_valid_q;
  assign bus_if.rsp_data  = rsp_data_q;

endmodule
